// File: rtl/data_mem_if.sv
// Load/store request and response handshake between the core and its data memory.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering one load/store at a time after a fixed latency.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input logic       clk,
    input logic       reset,
    data_mem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          lat_write;
    logic [31:0]   lat_addr, lat_wdata;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          enter_resp;
    logic          acc_write, acc_err;
    logic [31:0]   acc_addr, acc_wdata;
    logic [AW-1:0] acc_idx;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        enter_resp     = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the accepting edge, so use the live request fields.
    always_comb begin
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
        acc_idx = acc_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                cnt       <= CW'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (enter_resp) begin
                err_q <= acc_err;
                if (acc_err || acc_write) rdata_q <= '0;
                else                      rdata_q <= mem[acc_idx];
                if (!acc_err && acc_write) mem[acc_idx] <= acc_wdata;
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder at LATENCY 2, 1 and 4.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic        rv   [3];
    logic        rw   [3];
    logic        rrdy [3];
    logic [31:0] ra   [3];
    logic [31:0] wd   [3];
    logic        rqr  [3];
    logic        rsv  [3];
    logic        rse  [3];
    logic [31:0] rsd  [3];

    data_mem_if bus0 ();
    data_mem_if bus1 ();
    data_mem_if bus2 ();

    assign bus0.req_valid = rv[0];  assign bus0.req_write = rw[0];  assign bus0.req_addr = ra[0];
    assign bus0.req_wdata = wd[0];  assign bus0.resp_ready = rrdy[0];
    assign rqr[0] = bus0.req_ready; assign rsv[0] = bus0.resp_valid;
    assign rsd[0] = bus0.resp_rdata; assign rse[0] = bus0.resp_err;

    assign bus1.req_valid = rv[1];  assign bus1.req_write = rw[1];  assign bus1.req_addr = ra[1];
    assign bus1.req_wdata = wd[1];  assign bus1.resp_ready = rrdy[1];
    assign rqr[1] = bus1.req_ready; assign rsv[1] = bus1.resp_valid;
    assign rsd[1] = bus1.resp_rdata; assign rse[1] = bus1.resp_err;

    assign bus2.req_valid = rv[2];  assign bus2.req_write = rw[2];  assign bus2.req_addr = ra[2];
    assign bus2.req_wdata = wd[2];  assign bus2.resp_ready = rrdy[2];
    assign rqr[2] = bus2.req_ready; assign rsv[2] = bus2.resp_valid;
    assign rsd[2] = bus2.resp_rdata; assign rse[2] = bus2.resp_err;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut_l2 (.clk(clk), .reset(rst[0]), .bus(bus0));
    data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut_l1 (.clk(clk), .reset(rst[1]), .bus(bus1));
    data_mem_responder #(.DEPTH(64), .LATENCY(4)) dut_l4 (.clk(clk), .reset(rst[2]), .bus(bus2));

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction with idle resp_ready for v.hold cycles; expected result goes through the scoreboard.
    task automatic do_txn(input int k, input vec_t v, input int lat);
        int          c;
        logic [31:0] d0;
        logic        e0;
        exp_t        e;
        @(negedge clk);
        rv[k] = 1'b1; rw[k] = v.write; ra[k] = v.addr; wd[k] = v.wdata; rrdy[k] = 1'b0;
        c = 0;
        while (!rqr[k] && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (!rqr[k]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            rv[k] = 1'b0;
            return;
        end
        sb.push_back('{v.rdata, v.err});
        @(negedge clk);
        rv[k] = 1'b0; ra[k] = 32'hFFFF_FFF0; wd[k] = '1; rw[k] = ~v.write;
        c = 1;
        while (!rsv[k] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("latency", c, lat);
        if (!rsv[k]) begin
            void'(sb.pop_front());
            return;
        end
        d0 = rsd[k];
        e0 = rse[k];
        repeat (v.hold) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsv[k]}, 32'd1);
            chk("hold_rdata", rsd[k], d0);
            chk("hold_err", {31'd0, rse[k]}, {31'd0, e0});
            chk("hold_req_ready", {31'd0, rqr[k]}, 32'd0);
        end
        rrdy[k] = 1'b1;
        @(negedge clk);
        rrdy[k] = 1'b0;
        chk("idle_req_ready", {31'd0, rqr[k]}, 32'd1);
        chk("idle_resp_valid", {31'd0, rsv[k]}, 32'd0);
        e = sb.pop_front();
        chk("rdata", d0, e.rdata);
        chk("err", {31'd0, e0}, {31'd0, e.err});
    endtask

    // Loads with req_valid and resp_ready held high; checks latency and acceptance spacing.
    task automatic b2b(input int k, input int lat, input logic [31:0] addr,
                       input logic [31:0] exp_d, input int n);
        int   cyc, acc_cyc, nacc, done;
        exp_t e;
        @(negedge clk);
        rv[k] = 1'b1; rw[k] = 1'b0; ra[k] = addr; rrdy[k] = 1'b1;
        cyc = 0; acc_cyc = 0; nacc = 0; done = 0;
        while (done < n && cyc < 200) begin
            if (rsv[k]) begin
                chk("b2b_ready_in_resp", {31'd0, rqr[k]}, 32'd0);
                chk("b2b_latency", cyc - acc_cyc, lat);
                if (sb.size() == 0) begin
                    chk("b2b_unexpected_resp", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("b2b_rdata", rsd[k], e.rdata);
                    chk("b2b_err", {31'd0, rse[k]}, {31'd0, e.err});
                end
                done++;
                if (done == n) rv[k] = 1'b0;
            end else if (rqr[k] && rv[k]) begin
                chk("b2b_pending", sb.size(), 32'd0);
                if (nacc > 0) chk("b2b_gap", cyc - acc_cyc, lat + 1);
                sb.push_back('{exp_d, 1'b0});
                acc_cyc = cyc;
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        if (done != n) chk("b2b_timeout", done, n);
        rv[k] = 1'b0;
        rrdy[k] = 1'b0;
        sb.delete();
    endtask

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; rv[k] = 1'b0; rw[k] = 1'b0; rrdy[k] = 1'b0; ra[k] = '0; wd[k] = '0;
        end
        tbl[0]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b0, 0};
        tbl[1]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 0};
        tbl[2]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 5};
        tbl[3]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0,         1'b0, 0};
        tbl[4]  = '{1'b1, 32'h0000_0006, 32'hAAAA_5555, 32'h0,         1'b1, 0};
        tbl[5]  = '{1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0,         1'b1, 1};
        tbl[6]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
        tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 0};
        tbl[8]  = '{1'b0, 32'h0000_0104, 32'h0,         32'h0,         1'b1, 0};
        tbl[9]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0,         1'b0, 0};
        tbl[10] = '{1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0, 0};
        tbl[11] = '{1'b0, 32'h8000_0004, 32'h0,         32'h0,         1'b1, 0};

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_req_ready", {31'd0, rqr[k]}, 32'd1);
            chk("rst_resp_valid", {31'd0, rsv[k]}, 32'd0);
            chk("rst_rdata", rsd[k], 32'd0);
            chk("rst_err", {31'd0, rse[k]}, 32'd0);
            rst[k] = 1'b0;
        end

        for (int i = 0; i < 12; i++) do_txn(0, tbl[i], 2);

        // Reset while the store is waiting: no response and no memory write.
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h0000_000C; wd[0] = 32'h1234_5678;
        @(negedge clk);
        rv[0] = 1'b0;
        chk("wait_no_ready", {31'd0, rqr[0]}, 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("abort_resp_valid", {31'd0, rsv[0]}, 32'd0);
        chk("abort_req_ready", {31'd0, rqr[0]}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {31'd0, rsv[0]}, 32'd0);
        end
        do_txn(0, '{1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 0}, 2);
        do_txn(0, '{1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0, 0}, 2);

        do_txn(1, '{1'b1, 32'h0000_0020, 32'hA5A5_0001, 32'h0, 1'b0, 0}, 1);
        b2b(1, 1, 32'h0000_0020, 32'hA5A5_0001, 3);
        do_txn(2, '{1'b1, 32'h0000_0024, 32'h5A5A_0004, 32'h0, 1'b0, 2}, 4);
        b2b(2, 4, 32'h0000_0024, 32'h5A5A_0004, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
